// File: rtl/pga_pot_writer.sv
// Applies a {pot code, HGA bypass} gain request: writes the pot over mode-0 SPI and
// orders the bypass switch around the write so gain transients only ever dip.
module pga_pot_writer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter logic [7:0]  CMD_BYTE      = 8'h11,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] pga_code_i,
    input  logic       hga_bypass_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_no,
    output logic       hga_bypass_o,
    output logic [7:0] applied_code_o,
    output logic       done_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, BYP_PRE, SETTLE_PRE, CS_SETUP, SHIFT, CS_GAP, BYP_POST, SETTLE_POST, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [7:0]       code_q, code_d;
    logic             byp_q, byp_d;
    logic             hga_q, hga_d;
    logic [7:0]       applied_q, applied_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             ready;

    assign ready = (state_q == IDLE) || (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        settle_d  = settle_q;
        shreg_d   = shreg_q;
        code_d    = code_q;
        byp_d     = byp_q;
        hga_d     = hga_q;
        applied_d = applied_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        case (state_q)
            // DONE shares the accept path so back-to-back requests see the updated state
            IDLE, DONE: begin
                state_d = IDLE;
                if (valid_i) begin
                    code_d = pga_code_i;
                    byp_d  = hga_bypass_i;
                    if (pga_code_i == applied_q && hga_bypass_i == hga_q) begin
                        state_d = DONE;
                    end else if (hga_bypass_i && !hga_q) begin
                        state_d = BYP_PRE;
                        hga_d   = 1'b1;
                    end else begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        shreg_d = {CMD_BYTE, pga_code_i};
                        div_d   = '0;
                    end
                end
            end
            BYP_PRE: begin
                state_d  = SETTLE_PRE;
                settle_d = '0;
            end
            SETTLE_PRE: begin
                if (settle_q == SET_LAST) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    shreg_d = {CMD_BYTE, code_q};
                    div_d   = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bit_q == 5'd15) begin
                        state_d   = CS_GAP;
                        cs_n_d    = 1'b1;
                        applied_d = code_q;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            CS_GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (hga_q && !byp_q) begin
                        state_d = BYP_POST;
                        hga_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            BYP_POST: begin
                state_d  = SETTLE_POST;
                settle_d = '0;
            end
            SETTLE_POST: begin
                if (settle_q == SET_LAST) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            settle_q  <= '0;
            shreg_q   <= '0;
            hga_q     <= 1'b1;
            applied_q <= 8'h80;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            settle_q  <= settle_d;
            shreg_q   <= shreg_d;
            hga_q     <= hga_d;
            applied_q <= applied_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
        end
    end

    // Request latches are only read after an accept, so they need no reset
    always_ff @(posedge clk_i) begin
        code_q <= code_d;
        byp_q  <= byp_d;
    end

    assign ready_o        = ready;
    assign done_o         = (state_q == DONE);
    assign sclk_o         = sclk_q;
    assign mosi_o         = shreg_q[15];
    assign cs_no          = cs_n_q;
    assign hga_bypass_o   = hga_q;
    assign applied_code_o = applied_q;

endmodule

// File: tb/tb_pga_pot_writer.sv
// Directed bench for pga_pot_writer: table of gain requests plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_pga_pot_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pga_code = 8'h00;
    logic       hga_byp = 1'b0;
    logic       valid = 1'b0;
    logic       ready_o, sclk_o, mosi_o, cs_no, hga_bypass_o, done_o;
    logic [7:0] applied_code_o;

    int checks = 0;
    int failures = 0;

    pga_pot_writer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pga_code_i     (pga_code),
        .hga_bypass_i   (hga_byp),
        .valid_i        (valid),
        .ready_o        (ready_o),
        .sclk_o         (sclk_o),
        .mosi_o         (mosi_o),
        .cs_no          (cs_no),
        .hga_bypass_o   (hga_bypass_o),
        .applied_code_o (applied_code_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic        byp;
        logic [15:0] frame;
        int          nbits;
        int          cs_low;
        int          cs_fall;
        int          lat;
        int          hga_edge;
        logic        hga_fin;
        logic [7:0]  applied;
        logic        rdy1;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic request(input logic [7:0] c, input logic b);
        @(negedge clk);
        pga_code = c;
        hga_byp  = b;
        valid    = 1'b1;
        @(posedge clk);
    endtask

    // Watches cycles T+1.. after an accept edge until done_o; hold keeps valid_i high with changing data
    task automatic monitor(input bit hold, input logic ph_init,
                           output logic [15:0] frame, output int nbits, output int cs_low,
                           output int cs_fall, output int lat, output int hga_edge,
                           output logic rdy1);
        logic ps, pc, ph;
        ps = 1'b0; pc = 1'b1; ph = ph_init;
        frame = '0; nbits = 0; cs_low = 0; cs_fall = 0; lat = 0; hga_edge = 0; rdy1 = 1'bx;
        for (int rel = 1; rel <= 400; rel++) begin
            @(negedge clk);
            if (rel == 1) rdy1 = ready_o;
            if (cs_no === 1'b0) begin
                cs_low++;
                if (pc === 1'b1 && cs_fall == 0) cs_fall = rel;
            end
            if (sclk_o === 1'b1 && ps === 1'b0) begin
                frame = {frame[14:0], mosi_o};
                nbits++;
            end
            if (hga_bypass_o !== ph && hga_edge == 0) hga_edge = rel;
            ps = sclk_o; pc = cs_no; ph = hga_bypass_o;
            if (done_o === 1'b1) begin
                lat = rel;
                if (hold) pga_code = 8'h3C;
                break;
            end
            if (hold) pga_code = 8'hA5 ^ 8'(rel);
            else valid = 1'b0;
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done_o within 400 cycles");
        end
    endtask

    initial begin
        logic [15:0] frame;
        int nbits, cs_low, cs_fall, lat, hga_edge;
        logic rdy1;
        logic ph;

        vt[0] = '{8'hB1, 1'b1, 16'h11B1, 16, 132, 1,  137, 0,   1'b1, 8'hB1, 1'b0};
        vt[1] = '{8'h80, 1'b0, 16'h1180, 16, 132, 1,  154, 137, 1'b0, 8'h80, 1'b0};
        vt[2] = '{8'hDC, 1'b1, 16'h11DC, 16, 132, 18, 154, 1,   1'b1, 8'hDC, 1'b0};
        vt[3] = '{8'hDC, 1'b1, 16'h0000, 0,  0,   0,  1,   0,   1'b1, 8'hDC, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_sclk", sclk_o, 0);
        chk("rst_mosi", mosi_o, 0);
        chk("rst_cs", cs_no, 1);
        chk("rst_hga", hga_bypass_o, 1);
        chk("rst_applied", applied_code_o, 8'h80);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ready_o, 1);

        ph = 1'b1;
        for (int i = 0; i < 4; i++) begin
            request(vt[i].code, vt[i].byp);
            monitor(1'b0, ph, frame, nbits, cs_low, cs_fall, lat, hga_edge, rdy1);
            chk($sformatf("v%0d_frame", i), frame, vt[i].frame);
            chk($sformatf("v%0d_nbits", i), nbits, vt[i].nbits);
            chk($sformatf("v%0d_cs_low", i), cs_low, vt[i].cs_low);
            chk($sformatf("v%0d_cs_fall", i), cs_fall, vt[i].cs_fall);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_hga_edge", i), hga_edge, vt[i].hga_edge);
            chk($sformatf("v%0d_hga", i), hga_bypass_o, vt[i].hga_fin);
            chk($sformatf("v%0d_applied", i), applied_code_o, vt[i].applied);
            chk($sformatf("v%0d_ready_t1", i), rdy1, vt[i].rdy1);
            chk($sformatf("v%0d_ready_done", i), ready_o, 1);
            ph = vt[i].hga_fin;
        end

        // valid held high with changing data: only 5A goes out, then 3C is taken in the DONE cycle
        request(8'h5A, 1'b1);
        monitor(1'b1, 1'b1, frame, nbits, cs_low, cs_fall, lat, hga_edge, rdy1);
        chk("hold_frame", frame, 16'h115A);
        chk("hold_latency", lat, 137);
        chk("hold_applied", applied_code_o, 8'h5A);
        chk("hold_ready_done", ready_o, 1);
        monitor(1'b0, 1'b1, frame, nbits, cs_low, cs_fall, lat, hga_edge, rdy1);
        chk("b2b_ready_t1", rdy1, 0);
        chk("b2b_frame", frame, 16'h113C);
        chk("b2b_latency", lat, 137);
        chk("b2b_applied", applied_code_o, 8'h3C);

        // reset in the middle of the shift phase
        request(8'h77, 1'b1);
        for (int rel = 1; rel <= 63; rel++) begin
            @(negedge clk);
            if (rel == 1) valid = 1'b0;
        end
        chk("midframe_cs_low", cs_no, 0);
        chk("midframe_sclk_high", sclk_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", cs_no, 1);
        chk("arst_sclk", sclk_o, 0);
        chk("arst_mosi", mosi_o, 0);
        chk("arst_hga", hga_bypass_o, 1);
        chk("arst_applied", applied_code_o, 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", ready_o, 1);
        chk("arst_cs_idle", cs_no, 1);

        // 80/bypass now matches the reset state, so this must take the skip path
        request(8'h80, 1'b1);
        monitor(1'b0, 1'b1, frame, nbits, cs_low, cs_fall, lat, hga_edge, rdy1);
        chk("skip_after_rst_latency", lat, 1);
        chk("skip_after_rst_nbits", nbits, 0);
        chk("skip_after_rst_cs_low", cs_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
